// File: rtl/flow_ctrl_pkg.sv
// Shared types and micro-op encodings for the control-flow sequencer.
// The package itself has no configuration; the top module reads the
// FLOW_CTRL_FLAGS_EN macro.
package flow_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP,
        DRAIN,
        REDIRECT
    } flow_state_t;

    localparam logic [15:0] NOP_OP        = 16'h0000;
    localparam logic [15:0] PUSH_PC_BASE  = 16'h6008;
    localparam logic [15:0] POP_PC_BASE   = 16'h6010;
    localparam logic [15:0] PUSH_FLAGS_OP = 16'h6018;
    localparam logic [15:0] POP_FLAGS_OP  = 16'h6019;

    // Word index k selects which PC word the stack op moves.
    function automatic logic [15:0] push_pc_op(input logic [3:0] k);
        return PUSH_PC_BASE + {12'd0, k};
    endfunction

    function automatic logic [15:0] pop_pc_op(input logic [3:0] k);
        return POP_PC_BASE + {12'd0, k};
    endfunction

endpackage

// File: rtl/flow_ctrl_word_asm.sv
// Target-PC register for the sequencer. It is either loaded whole (CALL/INT
// target) or assembled one word at a time from popped stack data (RET/RTI).
module flow_ctrl_word_asm
    import flow_ctrl_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int WORD_WIDTH = 16,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [PC_WIDTH-1:0]   load_value,
    input  logic                  capture_en,
    input  logic [IDX_WIDTH-1:0]  capture_idx,
    input  logic [WORD_WIDTH-1:0] capture_data,
    output logic [PC_WIDTH-1:0]   value
);

    localparam int NW = PC_WIDTH / WORD_WIDTH;

    // Whole-value load wins over a word capture; otherwise the value holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (capture_en) begin
            for (int w = 0; w < NW; w++) begin
                if (capture_idx == IDX_WIDTH'(w)) begin
                    value[w*WORD_WIDTH +: WORD_WIDTH] <= capture_data;
                end
            end
        end
    end

endmodule

// File: rtl/flow_ctrl_fsm.sv
// Control-flow sequencer for CALL / RET / INT / RTI in the decode stage.
// It injects stack micro-ops while stalling fetch, then pulses change_pc.
// Optional feature macro: FLOW_CTRL_FLAGS_EN. When it is defined, INT also
// pushes flags and RTI also pops flags. When it is undefined, INT acts as
// CALL to int_vector and RTI acts as RET.
module flow_ctrl_fsm
    import flow_ctrl_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int WORD_WIDTH = 16,
    parameter int OP_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  call,
    input  logic                  ret,
    input  logic                  intr,
    input  logic                  rti,
    input  logic [WORD_WIDTH-1:0] rdst_value,
    input  logic [PC_WIDTH-1:0]   int_vector,
    input  logic [WORD_WIDTH-1:0] pop_data,
    output logic [OP_WIDTH-1:0]   inject_op,
    output logic [PC_WIDTH-1:0]   pc_out,
    output logic                  stall,
    output logic                  change_pc,
    output logic                  busy
);

    localparam int NW = PC_WIDTH / WORD_WIDTH;
    localparam int CW = $clog2(NW) + 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(NW - 1);

`ifdef FLOW_CTRL_FLAGS_EN
    localparam logic FLAGS_EN = 1'b1;
`else
    localparam logic FLAGS_EN = 1'b0;
`endif

    flow_state_t   state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          flags_step, flags_step_next;
    logic          int_pending, int_pending_next;

    logic                take_int, take_call, take_ret, take_rti;
    logic                pc_load;
    logic [PC_WIDTH-1:0] pc_load_value;
    logic                cap_en;
    logic [CW-1:0]       cap_idx;

    // A pending interrupt outranks every new request; the rest are dropped.
    assign take_int  = intr | int_pending;
    assign take_call = ~take_int & call;
    assign take_ret  = ~take_int & ~call & ret;
    assign take_rti  = ~take_int & ~call & ~ret & rti;

    // Sequencer state; a reset mid-sequence abandons it without a redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            flags_step  <= 1'b0;
            int_pending <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            flags_step  <= flags_step_next;
            int_pending <= int_pending_next;
        end
    end

    // Next state, word counter, and control for the target-PC register.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        flags_step_next  = flags_step;
        int_pending_next = int_pending;
        pc_load          = 1'b0;
        pc_load_value    = '0;
        cap_en           = 1'b0;
        cap_idx          = '0;

        if (state != IDLE && intr) begin
            int_pending_next = 1'b1;
        end

        case (state)
            IDLE: begin
                if (take_int) begin
                    state_next       = PUSH;
                    cnt_next         = '0;
                    flags_step_next  = FLAGS_EN;
                    int_pending_next = 1'b0;
                    pc_load          = 1'b1;
                    pc_load_value    = int_vector;
                end else if (take_call) begin
                    state_next      = PUSH;
                    cnt_next        = '0;
                    flags_step_next = 1'b0;
                    pc_load         = 1'b1;
                    pc_load_value   = PC_WIDTH'(rdst_value);
                end else if (take_ret || take_rti) begin
                    state_next      = POP;
                    cnt_next        = LAST_WORD;
                    flags_step_next = take_rti & FLAGS_EN;
                end
            end
            PUSH: begin
                if (flags_step) begin
                    flags_step_next = 1'b0;
                end else if (cnt == LAST_WORD) begin
                    state_next = REDIRECT;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            POP: begin
                cap_en  = (cnt != LAST_WORD);
                cap_idx = cnt + CW'(1);
                if (cnt == '0) begin
                    state_next = DRAIN;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            DRAIN: begin
                cap_en          = 1'b1;
                cap_idx         = '0;
                flags_step_next = 1'b0;
                state_next      = REDIRECT;
            end
            REDIRECT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode purely from registered state, so they change on edges only.
    always_comb begin
        inject_op = OP_WIDTH'(NOP_OP);
        stall     = 1'b0;
        change_pc = 1'b0;
        busy      = (state != IDLE);
        case (state)
            PUSH: begin
                stall     = 1'b1;
                inject_op = flags_step ? OP_WIDTH'(PUSH_FLAGS_OP)
                                       : OP_WIDTH'(push_pc_op(4'(cnt)));
            end
            POP: begin
                stall     = 1'b1;
                inject_op = OP_WIDTH'(pop_pc_op(4'(cnt)));
            end
            DRAIN: begin
                stall     = 1'b1;
                inject_op = flags_step ? OP_WIDTH'(POP_FLAGS_OP)
                                       : OP_WIDTH'(NOP_OP);
            end
            REDIRECT: begin
                change_pc = 1'b1;
            end
            default: begin
                inject_op = OP_WIDTH'(NOP_OP);
            end
        endcase
    end

    flow_ctrl_word_asm #(
        .PC_WIDTH  (PC_WIDTH),
        .WORD_WIDTH(WORD_WIDTH),
        .IDX_WIDTH (CW)
    ) u_word_asm (
        .clk         (clk),
        .reset       (reset),
        .load        (pc_load),
        .load_value  (pc_load_value),
        .capture_en  (cap_en),
        .capture_idx (cap_idx),
        .capture_data(pop_data),
        .value       (pc_out)
    );

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// Self-checking bench for flow_ctrl_fsm (PC_WIDTH=32, WORD_WIDTH=16).
// Honours FLOW_CTRL_FLAGS_EN the same way the design does.
module tb_flow_ctrl_fsm;

    localparam int PC_WIDTH   = 32;
    localparam int WORD_WIDTH = 16;
    localparam int OP_WIDTH   = 16;
    localparam int NW         = PC_WIDTH / WORD_WIDTH;

`ifdef FLOW_CTRL_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    localparam logic [15:0] OP_NOP   = 16'h0000;
    localparam logic [15:0] OP_PUSHF = 16'h6018;
    localparam logic [15:0] OP_POPF  = 16'h6019;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  call, ret, intr, rti;
    logic [WORD_WIDTH-1:0] rdst_value;
    logic [PC_WIDTH-1:0]   int_vector;
    logic [WORD_WIDTH-1:0] pop_data;
    logic [OP_WIDTH-1:0]   inject_op;
    logic [PC_WIDTH-1:0]   pc_out;
    logic                  stall, change_pc, busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] op;
        logic        stall;
        logic        chg;
        logic        busy;
        logic        chk_pc;
        logic [31:0] pc;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];

    flow_ctrl_fsm #(
        .PC_WIDTH  (PC_WIDTH),
        .WORD_WIDTH(WORD_WIDTH),
        .OP_WIDTH  (OP_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .call      (call),
        .ret       (ret),
        .intr      (intr),
        .rti       (rti),
        .rdst_value(rdst_value),
        .int_vector(int_vector),
        .pop_data  (pop_data),
        .inject_op (inject_op),
        .pc_out    (pc_out),
        .stall     (stall),
        .change_pc (change_pc),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [15:0] op, input logic st,
                                input logic chg, input logic chk,
                                input logic [31:0] pc, input logic [15:0] data);
        exp_t e;
        e.op     = op;
        e.stall  = st;
        e.chg    = chg;
        e.busy   = 1'b1;
        e.chk_pc = chk;
        e.pc     = pc;
        e.data   = data;
        return e;
    endfunction

    task automatic clear_inputs();
        call       = 1'b0;
        ret        = 1'b0;
        intr       = 1'b0;
        rti        = 1'b0;
        rdst_value = '0;
        int_vector = '0;
        pop_data   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({inject_op, stall, change_pc, busy, pc_out} !== {16'h0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got op=%h stall=%b chg=%b busy=%b pc=%h, want all zero",
                     inject_op, stall, change_pc, busy, pc_out);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({inject_op, stall, change_pc, busy} !== {16'h0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_idle: got op=%h stall=%b chg=%b busy=%b, want idle",
                     inject_op, stall, change_pc, busy);
        end
    endtask

    task automatic test_call();
        do_reset();
        call = 1'b1;
        rdst_value = 16'h0F0F;
        @(negedge clk);
        call = 1'b0;
        checks++;
        if ({inject_op, stall, change_pc, busy, pc_out} !== {16'h6008, 1'b1, 1'b0, 1'b1, 32'h0000_0F0F}) begin
            failures++;
            $display("[TB] FAIL call_c1: got op=%h stall=%b chg=%b busy=%b pc=%h, want 6008/1/0/1/00000f0f",
                     inject_op, stall, change_pc, busy, pc_out);
        end
        @(negedge clk);
        checks++;
        if ({inject_op, stall, change_pc, busy} !== {16'h6009, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL call_c2: got op=%h stall=%b chg=%b busy=%b, want 6009/1/0/1",
                     inject_op, stall, change_pc, busy);
        end
        @(negedge clk);
        checks++;
        if ({inject_op, stall, change_pc, busy, pc_out} !== {16'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0F0F}) begin
            failures++;
            $display("[TB] FAIL call_c3: got op=%h stall=%b chg=%b busy=%b pc=%h, want 0000/0/1/1/00000f0f",
                     inject_op, stall, change_pc, busy, pc_out);
        end
        @(negedge clk);
        checks++;
        if ({inject_op, stall, change_pc, busy, pc_out} !== {16'h0, 1'b0, 1'b0, 1'b0, 32'h0000_0F0F}) begin
            failures++;
            $display("[TB] FAIL call_c4: got op=%h stall=%b chg=%b busy=%b pc=%h, want idle holding 00000f0f",
                     inject_op, stall, change_pc, busy, pc_out);
        end
    endtask

    task automatic test_ret();
        do_reset();
        ret = 1'b1;
        @(negedge clk);
        ret = 1'b0;
        checks++;
        if ({inject_op, stall, busy} !== {16'h6011, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL ret_c1: got op=%h stall=%b busy=%b, want 6011/1/1", inject_op, stall, busy);
        end
        @(negedge clk);
        pop_data = 16'h0001;
        checks++;
        if ({inject_op, stall, busy} !== {16'h6010, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL ret_c2: got op=%h stall=%b busy=%b, want 6010/1/1", inject_op, stall, busy);
        end
        @(negedge clk);
        pop_data = 16'hABCD;
        checks++;
        if ({inject_op, stall, change_pc, busy} !== {16'h0, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL ret_drain: got op=%h stall=%b chg=%b busy=%b, want 0000/1/0/1",
                     inject_op, stall, change_pc, busy);
        end
        @(negedge clk);
        pop_data = 16'h0;
        checks++;
        if ({inject_op, stall, change_pc, pc_out} !== {16'h0, 1'b0, 1'b1, 32'h0001_ABCD}) begin
            failures++;
            $display("[TB] FAIL ret_redirect: got op=%h stall=%b chg=%b pc=%h, want 0000/0/1/0001abcd",
                     inject_op, stall, change_pc, pc_out);
        end
    endtask

    task automatic test_int();
        logic [15:0] ops[$];
        do_reset();
        if (FLAGS_ON) ops.push_back(OP_PUSHF);
        for (int k = 0; k < NW; k++) ops.push_back(16'h6008 + 16'(k));
        intr = 1'b1;
        int_vector = 32'h0000_0020;
        @(negedge clk);
        intr = 1'b0;
        foreach (ops[i]) begin
            checks++;
            if ({inject_op, stall, change_pc, pc_out} !== {ops[i], 1'b1, 1'b0, 32'h20}) begin
                failures++;
                $display("[TB] FAIL int_push%0d: got op=%h stall=%b chg=%b pc=%h, want %h/1/0/00000020",
                         i, inject_op, stall, change_pc, pc_out, ops[i]);
            end
            @(negedge clk);
        end
        checks++;
        if ({inject_op, stall, change_pc, pc_out} !== {16'h0, 1'b0, 1'b1, 32'h20}) begin
            failures++;
            $display("[TB] FAIL int_redirect: got op=%h stall=%b chg=%b pc=%h, want 0000/0/1/00000020",
                     inject_op, stall, change_pc, pc_out);
        end
    endtask

    task automatic test_int_during_busy();
        logic [15:0] ops[$];
        do_reset();
        if (FLAGS_ON) ops.push_back(OP_PUSHF);
        for (int k = 0; k < NW; k++) ops.push_back(16'h6008 + 16'(k));
        call = 1'b1;
        rdst_value = 16'h1234;
        @(negedge clk);
        call = 1'b0;
        @(negedge clk);
        checks++;
        if (inject_op !== 16'h6009) begin
            failures++;
            $display("[TB] FAIL busy_int_push: got op=%h, want 6009", inject_op);
        end
        intr = 1'b1;
        int_vector = 32'h0000_0040;
        @(negedge clk);
        intr = 1'b0;
        checks++;
        if ({change_pc, pc_out} !== {1'b1, 32'h0000_1234}) begin
            failures++;
            $display("[TB] FAIL busy_int_call_redirect: got chg=%b pc=%h, want 1/00001234", change_pc, pc_out);
        end
        @(negedge clk);
        checks++;
        if ({inject_op, change_pc, busy} !== {16'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL busy_int_gap: got op=%h chg=%b busy=%b, want 0000/0/0", inject_op, change_pc, busy);
        end
        @(negedge clk);
        foreach (ops[i]) begin
            checks++;
            if ({inject_op, stall, pc_out} !== {ops[i], 1'b1, 32'h40}) begin
                failures++;
                $display("[TB] FAIL busy_int_entry%0d: got op=%h stall=%b pc=%h, want %h/1/00000040",
                         i, inject_op, stall, pc_out, ops[i]);
            end
            @(negedge clk);
        end
        checks++;
        if ({change_pc, pc_out} !== {1'b1, 32'h40}) begin
            failures++;
            $display("[TB] FAIL busy_int_redirect: got chg=%b pc=%h, want 1/00000040", change_pc, pc_out);
        end
    endtask

    task automatic test_call_ret_together();
        do_reset();
        call = 1'b1;
        ret  = 1'b1;
        rdst_value = 16'h00AA;
        @(negedge clk);
        call = 1'b0;
        ret  = 1'b0;
        for (int k = 0; k < NW; k++) begin
            checks++;
            if (inject_op !== 16'h6008 + 16'(k)) begin
                failures++;
                $display("[TB] FAIL priority_push%0d: got op=%h, want %h", k, inject_op, 16'h6008 + 16'(k));
            end
            @(negedge clk);
        end
        checks++;
        if ({change_pc, pc_out} !== {1'b1, 32'h0000_00AA}) begin
            failures++;
            $display("[TB] FAIL priority_redirect: got chg=%b pc=%h, want 1/000000aa", change_pc, pc_out);
        end
    endtask

    task automatic test_reset_during_pop();
        do_reset();
        ret = 1'b1;
        @(negedge clk);
        ret = 1'b0;
        @(negedge clk);
        checks++;
        if (inject_op !== 16'h6010) begin
            failures++;
            $display("[TB] FAIL rstpop_second: got op=%h, want 6010", inject_op);
        end
        pop_data = 16'h5555;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({inject_op, stall, change_pc, busy, pc_out} !== {16'h0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("[TB] FAIL rstpop_clear: got op=%h stall=%b chg=%b busy=%b pc=%h, want all zero",
                     inject_op, stall, change_pc, busy, pc_out);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({change_pc, busy} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL rstpop_no_redirect: cycle %0d got chg=%b busy=%b, want 0/0", c, change_pc, busy);
            end
        end
    endtask

    task automatic test_random(input int cycles);
        exp_t        cur;
        logic [31:0] mpc;
        logic [31:0] addr;
        logic [15:0] dat;
        bit          pend;
        bit          is_rti;
        do_reset();
        exp_q.delete();
        mpc  = '0;
        pend = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
            end else begin
                cur = mk(OP_NOP, 1'b0, 1'b0, 1'b1, mpc, 16'h0);
                cur.busy = 1'b0;
            end
            pop_data = cur.data;
            checks++;
            if ({inject_op, stall, change_pc, busy} !== {cur.op, cur.stall, cur.chg, cur.busy}) begin
                failures++;
                $display("[TB] FAIL rand_ctl cycle %0d: got op=%h stall=%b chg=%b busy=%b, want %h/%b/%b/%b",
                         c, inject_op, stall, change_pc, busy, cur.op, cur.stall, cur.chg, cur.busy);
            end
            if (cur.chk_pc) begin
                checks++;
                if (pc_out !== cur.pc) begin
                    failures++;
                    $display("[TB] FAIL rand_pc cycle %0d: got pc=%h, want %h", c, pc_out, cur.pc);
                end
            end
            call       = ($urandom_range(0, 5) == 0);
            ret        = ($urandom_range(0, 5) == 0);
            rti        = ($urandom_range(0, 5) == 0);
            intr       = ($urandom_range(0, 9) == 0);
            rdst_value = 16'($urandom);
            int_vector = $urandom;
            if (cur.busy) begin
                if (intr) pend = 1'b1;
            end else if (intr || pend) begin
                pend = 1'b0;
                mpc  = int_vector;
                if (FLAGS_ON) exp_q.push_back(mk(OP_PUSHF, 1'b1, 1'b0, 1'b1, mpc, 16'h0));
                for (int k = 0; k < NW; k++)
                    exp_q.push_back(mk(16'h6008 + 16'(k), 1'b1, 1'b0, 1'b1, mpc, 16'h0));
                exp_q.push_back(mk(OP_NOP, 1'b0, 1'b1, 1'b1, mpc, 16'h0));
            end else if (call) begin
                mpc = {16'h0, rdst_value};
                for (int k = 0; k < NW; k++)
                    exp_q.push_back(mk(16'h6008 + 16'(k), 1'b1, 1'b0, 1'b1, mpc, 16'h0));
                exp_q.push_back(mk(OP_NOP, 1'b0, 1'b1, 1'b1, mpc, 16'h0));
            end else if (ret || rti) begin
                is_rti = !ret && rti;
                addr   = $urandom;
                mpc    = addr;
                for (int k = NW - 1; k >= 0; k--) begin
                    if (k == NW - 1) dat = 16'($urandom);
                    else             dat = addr[(k+1)*WORD_WIDTH +: WORD_WIDTH];
                    exp_q.push_back(mk(16'h6010 + 16'(k), 1'b1, 1'b0, 1'b0, addr, dat));
                end
                exp_q.push_back(mk((is_rti && FLAGS_ON) ? OP_POPF : OP_NOP, 1'b1, 1'b0, 1'b0,
                                   addr, addr[WORD_WIDTH-1:0]));
                exp_q.push_back(mk(OP_NOP, 1'b0, 1'b1, 1'b1, addr, 16'h0));
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_call();
        test_ret();
        test_int();
        test_int_during_busy();
        test_call_ret_together();
        test_reset_during_pop();
        test_random(800);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/flow_ctrl_fsm.md
Name: flow_ctrl_fsm

Overview:
- Parametrised control-flow sequencer in the decode stage. Handles CALL, RET, INT and RTI.
- Injects stack micro-op opcodes into the pipeline and stalls fetch while doing so.
- Then redirects the PC for one cycle.
- Generalises the CALL-only two-word push sequencer to N-word PCs, pop sequences and interrupt entry/exit.

Parameters:
- PC_WIDTH, 32, program-counter width.
- WORD_WIDTH, 16, stack/data word width. PC_WIDTH must be a multiple of WORD_WIDTH. NW = PC_WIDTH/WORD_WIDTH, range 1..8.
- OP_WIDTH, 16, injected instruction width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- call  in  1  CALL decoded this cycle.
- ret  in  1  RET decoded this cycle.
- intr  in  1  interrupt request, level, sampled each cycle.
- rti  in  1  RTI decoded this cycle.
- rdst_value  in  WORD_WIDTH  CALL target.
- int_vector  in  PC_WIDTH  INT target.
- pop_data  in  WORD_WIDTH  memory read data, valid one cycle after a POP op is presented.
- inject_op  out  OP_WIDTH  micro-op to insert into the pipeline; NOP_OP when idle.
- pc_out  out  PC_WIDTH  redirect target.
- stall  out  1  freeze fetch/decode.
- change_pc  out  1  one-cycle redirect strobe.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; inject_op=NOP_OP, pc_out=0, stall=0, change_pc=0, busy=0; word counter, capture register and pending-interrupt flag cleared. Reset mid-sequence aborts the sequence with no redirect.
- States: IDLE, PUSH, POP, DRAIN, REDIRECT.
- Acceptance in IDLE. Priority is intr (or a pending interrupt) > call > ret > rti. Lower-priority simultaneous requests are dropped.
- call, ret and rti arriving while busy are ignored. intr arriving while busy sets the pending flag; it is serviced on the first IDLE cycle.
- CALL: latch pc_out = zero-extended rdst_value. Enter PUSH with k=0. Each PUSH cycle: inject_op = PUSH_PC_OP(k), stall=1, k++. After k=NW-1, go to REDIRECT.
- INT: latch pc_out = int_vector. The first PUSH cycle emits PUSH_FLAGS_OP, then PUSH_PC_OP(0..NW-1), low word first.
- RET: enter POP with k=NW-1. Each POP cycle: inject_op = POP_PC_OP(k), stall=1, k--. In each cycle after a POP_PC, pop_data is written into pc_out word slice k+1 (captured high word first).
- After the POP_PC_OP(0) cycle, go to DRAIN: inject_op=NOP_OP, stall=1, capture word 0. Then go to REDIRECT.
- RTI: same as RET, but DRAIN is replaced by one cycle emitting POP_FLAGS_OP (stall=1) while word 0 is captured. Then go to REDIRECT.
- REDIRECT: change_pc=1, stall=0, inject_op=NOP_OP, pc_out holds the target. Next state is IDLE.
- pc_out holds its value until the next accepted request.
- Latency from acceptance edge to the change_pc cycle:
  - CALL: NW+1 cycles.
  - INT: NW+2 cycles.
  - RET: NW+2 cycles.
  - RTI: NW+2 cycles.
- Outputs are registered, so inject_op appears the cycle after the request is sampled.
- NW=1: a single PUSH/POP cycle. Counter wrap cannot occur because the counter width is clog2(NW)+1.

Optional Feature:
- FLOW_CTRL_FLAGS_EN.
- Defined: INT pushes flags and RTI pops flags as described above.
- Undefined: INT behaves as CALL with target int_vector, and RTI behaves as RET. No PUSH_FLAGS_OP or POP_FLAGS_OP is ever emitted.

Decomposition:
- Package flow_ctrl_pkg holds:
  - state enum;
  - NOP_OP=16'h0000;
  - PUSH_PC_OP(k)=16'h6008+k;
  - POP_PC_OP(k)=16'h6010+k;
  - PUSH_FLAGS_OP=16'h6018;
  - POP_FLAGS_OP=16'h6019.
- One sub-module, flow_ctrl_word_asm, is natural: the indexed capture register that assembles pc_out from popped words.

Test Plan (PC_WIDTH=32, WORD_WIDTH=16):
- CALL: call=1 for one cycle, rdst_value=16'h0F0F. Expected:
  - cycle 1: inject_op=16'h6008, stall=1, pc_out=32'h0000_0F0F;
  - cycle 2: inject_op=16'h6009, stall=1;
  - cycle 3: change_pc=1, stall=0, inject_op=0;
  - cycle 4: idle.
- RET: ret=1, pop_data=16'h0001 then 16'hABCD. Expected:
  - ops 6011, 6010, NOP(stall), then change_pc=1;
  - pc_out=32'h0001_ABCD.
- INT with FLAGS_EN defined: intr=1, int_vector=32'h0000_0020. Expected:
  - ops 6018, 6008, 6009;
  - change_pc=1 with pc_out=32'h20.
- Same INT stimulus without the macro: ops 6008, 6009 only.
- Interrupt during a busy sequence: intr pulses during a CALL's second push. Expected: the CALL completes its redirect, then INT entry starts on the next cycle. Also call+ret asserted together: only CALL runs.
- Reset during POP: reset=1 on the second POP cycle. Expected on the next cycle: all outputs zero, busy=0, and no change_pc pulse ever occurs for that RET.
